seq_add_sub: RTL

SEQ_ADD_SUB -- requirements
Module: seq_add_sub

---
 rtl/seq_add_sub_pkg.sv | 16 +
 rtl/seq_add_sub_digit_adder.sv | 30 +++
 rtl/seq_add_sub.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/seq_add_sub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state
// encoding and the add/subtract mode encoding of the 'sub' input.
package seq_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage : seq_add_sub_pkg

// File: rtl/seq_add_sub_digit_adder.sv
// DIGIT-bit ripple-carry adder. Besides the carry out it exposes the carry
// into its most significant bit, which the parent uses for signed overflow.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    // Ripple the carry bit by bit, capturing the carry entering the top bit.
    always_comb begin
        logic c;
        c      = cin_i;
        sum_o  = '0;
        cmsb_o = cin_i;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                cmsb_o = c;
            end
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end

endmodule : digit_adder

// File: rtl/seq_add_sub.sv
// Digit-serial adder/subtractor. Operands are latched on start, then DIGIT
// bits are summed per cycle for WIDTH/DIGIT cycles; the sum digits are
// shifted into an accumulator from the MSB end so the result lands aligned.
// Subtraction is A + ~B + 1 (inverted B, carry-in of 1).
module seq_add_sub
    import seq_add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("seq_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    mode_e              mode;
    logic [DIGIT-1:0]   dig_sum;
    logic               dig_cout;
    logic               dig_cmsb;
    logic [WIDTH-1:0]   acc_shift;

    assign mode = mode_e'(sub);

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a_i    (a_q[DIGIT-1:0]),
        .b_i    (b_q[DIGIT-1:0]),
        .cin_i  (carry_q),
        .sum_o  (dig_sum),
        .cout_o (dig_cout),
        .cmsb_o (dig_cmsb)
    );

    // New sum digit enters at the MSB end; with a single step it is the whole word.
    if (DIGIT == WIDTH) begin : g_acc_full
        assign acc_shift = dig_sum;
    end else begin : g_acc_part
        assign acc_shift = {dig_sum, acc_q[WIDTH-1:DIGIT]};
    end

    // Next-state, datapath updates and status outputs of the IDLE/RUN/DONE FSM.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = (mode == MODE_SUB) ? ~b : b;
                    carry_d = (mode == MODE_SUB);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = acc_shift;
                carry_d = dig_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    result_d = acc_shift;
                    cout_d   = dig_cout;
                    ovf_d    = dig_cmsb ^ dig_cout;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule : seq_add_sub
